fifo_rd_ctrl: RTL and testbench

Synchronous read-side controller for the 512×18 `fifo` device model. It drives `fifo_ren_`, `fifo_oe_` and `fifo_ld_` from the system clock, which is also the FIFO read clock, and captures `fifo_q`. Captured words are presented on a valid/ready stream through a 3-entry output buffer. Optionally it reads back the FIFO's programmable almost-empty and almost-full offset registers.

---
 rtl/fifo_rd_ctrl.sv | 156 +++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for a 512x18 FIFO, streaming captured words through a 3-entry buffer.
// Define FIFO_RD_OFFSET_READBACK_EN to add readback of the almost-empty/almost-full offset registers.
module fifo_rd_ctrl #(
   parameter int WIDTH   = 18,
   parameter int CW      = 16,
   parameter int OFF_RST = 63
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] fifo_q,
   input  logic             fifo_ef_,
   input  logic             fifo_pae_,
   output logic             fifo_ren_,
   output logic             fifo_oe_,
   output logic             fifo_ld_,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             almost_empty,
   output logic [CW-1:0]    rd_count
`ifdef FIFO_RD_OFFSET_READBACK_EN
   ,
   input  logic             cfg_req,
   output logic             cfg_done,
   output logic [10:0]      cfg_pae_off,
   output logic [10:0]      cfg_paf_off
`endif
);

`ifdef FIFO_RD_OFFSET_READBACK_EN
   typedef enum logic [3:0] {BOOT, WARM, RUN, CFG_DRAIN, CFG_LD, CFG_RD0, CFG_RD1, CFG_CAP, CFG_END} state_t;
`else
   typedef enum logic [1:0] {BOOT, WARM, RUN} state_t;
`endif

   state_t           r_state;
   logic             r_ren_;
   logic             r_oe_;
   logic             r_inflight;
   logic             r_ae;
   logic [1:0]       r_cnt;
   logic [WIDTH-1:0] r_buf [3];
   logic [CW-1:0]    r_count;
   logic             w_pop;
   logic             w_xfer;
   logic             w_ren_n;
   logic [1:0]       w_wr_idx;
   logic [1:0]       w_cnt_n;
   logic [WIDTH-1:0] w_buf [3];

`ifdef FIFO_RD_OFFSET_READBACK_EN
   logic             r_ld_;
   logic             r_done;
   logic [10:0]      r_pae;
   logic [10:0]      r_paf;
   assign fifo_ld_    = r_ld_;
   assign cfg_done    = r_done;
   assign cfg_pae_off = r_pae;
   assign cfg_paf_off = r_paf;
`else
   assign fifo_ld_    = 1'b1;
`endif

   // a pop at edge N puts its word on fifo_q, captured into the buffer at edge N+1
   assign w_pop    = ~r_ren_ & fifo_ld_ & fifo_ef_;
   assign w_xfer   = m_valid & m_ready;
   assign w_wr_idx = r_cnt - {1'b0, w_xfer};
   assign w_cnt_n  = w_wr_idx + {1'b0, r_inflight};
   assign w_ren_n  = ({1'b0, w_cnt_n} + {2'b00, w_pop}) > 3'd2;

   assign fifo_ren_    = r_ren_;
   assign fifo_oe_     = r_oe_;
   assign m_data       = r_buf[0];
   assign m_valid      = r_cnt != 2'd0;
   assign almost_empty = r_ae;
   assign rd_count     = r_count;

   always_comb begin
      w_buf[0] = w_xfer ? r_buf[1] : r_buf[0];
      w_buf[1] = w_xfer ? r_buf[2] : r_buf[1];
      w_buf[2] = r_buf[2];
      if (r_inflight && w_wr_idx != 2'd3) w_buf[w_wr_idx] = fifo_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= BOOT;
         r_ren_     <= 1'b1;
         r_oe_      <= 1'b1;
         r_inflight <= 1'b0;
         r_ae       <= 1'b0;
         r_cnt      <= 2'd0;
         r_buf      <= '{default: '0};
         r_count    <= '0;
`ifdef FIFO_RD_OFFSET_READBACK_EN
         r_ld_      <= 1'b1;
         r_done     <= 1'b0;
         r_pae      <= 11'(OFF_RST);
         r_paf      <= 11'(OFF_RST);
`endif
      end else begin
         r_oe_      <= 1'b0;
         r_inflight <= w_pop;
         r_ae       <= ~fifo_pae_;
         r_cnt      <= w_cnt_n;
         r_buf      <= w_buf;
         r_count    <= r_count + CW'(w_xfer);
         case (r_state)
            BOOT: r_state <= WARM;
            WARM: r_state <= RUN;
`ifdef FIFO_RD_OFFSET_READBACK_EN
            RUN: begin
               r_state <= cfg_req ? CFG_DRAIN : RUN;
               r_ren_  <= cfg_req | w_ren_n;
            end
            CFG_DRAIN: begin
               r_ren_ <= 1'b1;
               if (!r_inflight) begin
                  r_state <= CFG_LD;
                  r_ld_   <= 1'b0;
               end
            end
            CFG_LD: begin
               r_state <= CFG_RD0;
               r_ren_  <= 1'b0;
            end
            CFG_RD0: r_state <= CFG_RD1;
            // fifo_q now holds the almost-empty offset; the almost-full one follows a cycle later
            CFG_RD1: begin
               r_state <= CFG_CAP;
               r_ren_  <= 1'b1;
               r_pae   <= fifo_q[10:0];
            end
            CFG_CAP: begin
               r_state <= CFG_END;
               r_ld_   <= 1'b1;
               r_done  <= 1'b1;
               r_paf   <= fifo_q[10:0];
            end
            CFG_END: begin
               r_state <= RUN;
               r_done  <= 1'b0;
            end
`else
            RUN: r_ren_ <= w_ren_n;
`endif
            default: r_state <= BOOT;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(r_inflight && !w_xfer && r_cnt == 2'd3));
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized bench with a queue-based FIFO model and an in-order stream scoreboard.
`timescale 1ns/1ps
module tb_fifo_rd_ctrl;
   localparam int WIDTH = 18;
   localparam int CW    = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] fifo_q = '0;
   logic             fifo_ef_ = 1'b0;
   logic             fifo_pae_ = 1'b0;
   logic             fifo_ren_, fifo_oe_, fifo_ld_;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic             almost_empty;
   logic [CW-1:0]    rd_count;
`ifdef FIFO_RD_OFFSET_READBACK_EN
   logic             cfg_req = 1'b0;
   logic             cfg_done;
   logic [10:0]      cfg_pae_off, cfg_paf_off;
`endif

   int n_chk = 0;
   int n_fail = 0;

   fifo_rd_ctrl dut (
      .clk(clk), .rst(rst), .fifo_q(fifo_q), .fifo_ef_(fifo_ef_), .fifo_pae_(fifo_pae_),
      .fifo_ren_(fifo_ren_), .fifo_oe_(fifo_oe_), .fifo_ld_(fifo_ld_),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .almost_empty(almost_empty), .rd_count(rd_count)
`ifdef FIFO_RD_OFFSET_READBACK_EN
      , .cfg_req(cfg_req), .cfg_done(cfg_done), .cfg_pae_off(cfg_pae_off), .cfg_paf_off(cfg_paf_off)
`endif
   );

   always #20 clk = ~clk;

   // FIFO device model: data queue, flags updated on the read clock, offset registers read with ld_ low
   logic [WIDTH-1:0] fq[$];
   int  pops = 0, pop_e = -1, cyc = 0, pae_off = 5, paf_off = 7;
   bit  sel = 1'b0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!fifo_ld_) begin
         if (!fifo_ren_) fifo_q <= WIDTH'(sel ? paf_off : pae_off);
         sel <= fifo_ren_ ? 1'b0 : ~sel;
      end else if (!fifo_ren_ && fifo_ef_) begin
         fifo_q <= fq.pop_front();
         pops   <= pops + 1;
         pop_e  <= cyc;
      end
      fifo_ef_  <= fq.size() != 0;
      fifo_pae_ <= !(fq.size() <= pae_off);
   end

   // stream collector: records accepted words and the cycle they were accepted in
   logic [WIDTH-1:0] got[$];
   int  got_cyc[$];
   bit  ld_low = 1'b0;
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         got.push_back(m_data);
         got_cyc.push_back(cyc);
      end
      if (fifo_ld_ !== 1'b1) ld_low = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick(2);
      got.delete();
      got_cyc.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      m_ready = 1'b1;
      rst = 1'b1;
      for (int i = 1; i <= 4; i++) fq.push_back(WIDTH'(i));
      tick(3);
      n_chk++; if (fifo_ren_ !== 1'b1) begin n_fail++; $display("FAIL rst_ren: got %b want 1", fifo_ren_); end
      n_chk++; if (fifo_oe_ !== 1'b1) begin n_fail++; $display("FAIL rst_oe: got %b want 1", fifo_oe_); end
      n_chk++; if (fifo_ld_ !== 1'b1) begin n_fail++; $display("FAIL rst_ld: got %b want 1", fifo_ld_); end
      n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", m_valid); end
      n_chk++; if (m_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", m_data); end
      n_chk++; if (rd_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", rd_count); end
      n_chk++; if (almost_empty !== 1'b0) begin n_fail++; $display("FAIL rst_ae: got %b want 0", almost_empty); end
`ifdef FIFO_RD_OFFSET_READBACK_EN
      n_chk++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", cfg_done); end
      n_chk++; if (cfg_pae_off !== 11'd63) begin n_fail++; $display("FAIL rst_pae: got %0d want 63", cfg_pae_off); end
      n_chk++; if (cfg_paf_off !== 11'd63) begin n_fail++; $display("FAIL rst_paf: got %0d want 63", cfg_paf_off); end
`endif
      got.delete();
      got_cyc.delete();
      rst = 1'b0;
      tick(1);
      n_chk++; if (fifo_oe_ !== 1'b0) begin n_fail++; $display("FAIL start_oe: got %b want 0", fifo_oe_); end
      for (int c = 0; c < 30 && got.size() < 4; c++) tick(1);
      n_chk++; if (got.size() != 4) begin n_fail++; $display("FAIL start_words: got %0d words want 4", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         n_chk++; if (got[i] !== WIDTH'(i + 1)) begin n_fail++; $display("FAIL start_data[%0d]: got %0d want %0d", i, got[i], i + 1); end
         if (i > 0) begin
            n_chk++; if (got_cyc[i] != got_cyc[i-1] + 1) begin n_fail++; $display("FAIL start_consec[%0d]: got cyc %0d want %0d", i, got_cyc[i], got_cyc[i-1] + 1); end
         end
      end
      tick(5);
      n_chk++; if (rd_count !== CW'(4)) begin n_fail++; $display("FAIL start_count: got %0d want 4", rd_count); end
      n_chk++; if (fifo_oe_ !== 1'b0) begin n_fail++; $display("FAIL start_oe_hold: got %b want 0", fifo_oe_); end
   endtask

   task automatic test_empty;
      logic [WIDTH-1:0] w;
      m_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         tick(1);
         n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid: got %b want 0", m_valid); end
      end
      n_chk++; if (rd_count !== '0) begin n_fail++; $display("FAIL empty_count: got %0d want 0", rd_count); end
      w = WIDTH'($urandom);
      fq.push_back(w);
      for (int c = 0; c < 20 && !m_valid; c++) tick(1);
      n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL empty_arrive: got valid %b want 1", m_valid); end
      n_chk++; if (cyc != pop_e + 2) begin n_fail++; $display("FAIL empty_latency: got cyc %0d want %0d", cyc, pop_e + 2); end
      n_chk++; if (m_data !== w) begin n_fail++; $display("FAIL empty_data: got %h want %h", m_data, w); end
      m_ready = 1'b1;
      tick(3);
      n_chk++; if (rd_count !== CW'(1)) begin n_fail++; $display("FAIL empty_count1: got %0d want 1", rd_count); end
      n_chk++; if (got.size() != 1 || got[0] !== w) begin n_fail++; $display("FAIL empty_stream: got %0d words want 1 word %h", got.size(), w); end
   endtask

   task automatic test_backpressure;
      logic [WIDTH-1:0] w[10];
      int p0;
      m_ready = 1'b0;
      do_reset();
      p0 = pops;
      for (int i = 0; i < 10; i++) begin
         w[i] = WIDTH'($urandom);
         fq.push_back(w[i]);
      end
      for (int c = 0; c < 8; c++) begin
         tick(1);
         if (m_valid) begin
            n_chk++; if (m_data !== w[0]) begin n_fail++; $display("FAIL bp_hold: got %h want %h", m_data, w[0]); end
         end
      end
      n_chk++; if (pops - p0 != 3) begin n_fail++; $display("FAIL bp_depth: got %0d pops want 3", pops - p0); end
      n_chk++; if (fifo_ren_ !== 1'b1) begin n_fail++; $display("FAIL bp_ren: got %b want 1", fifo_ren_); end
      n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", m_valid); end
      n_chk++; if (almost_empty !== 1'b0) begin n_fail++; $display("FAIL bp_ae_hi: got %b want 0", almost_empty); end
      m_ready = 1'b1;
      for (int c = 0; c < 40 && got.size() < 10; c++) tick(1);
      n_chk++; if (got.size() != 10) begin n_fail++; $display("FAIL bp_words: got %0d want 10", got.size()); end
      for (int i = 0; i < got.size() && i < 10; i++) begin
         n_chk++; if (got[i] !== w[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, got[i], w[i]); end
      end
      tick(3);
      n_chk++; if (rd_count !== CW'(10)) begin n_fail++; $display("FAIL bp_count: got %0d want 10", rd_count); end
      n_chk++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL bp_ae_lo: got %b want 1", almost_empty); end
`ifndef FIFO_RD_OFFSET_READBACK_EN
      n_chk++; if (ld_low) begin n_fail++; $display("FAIL ld_const: got ld_ low want always 1"); end
`endif
   endtask

   task automatic test_reset_mid;
      logic [WIDTH-1:0] w[3];
      m_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 2; i++) fq.push_back(WIDTH'($urandom));
      for (int c = 0; c < 30 && got.size() < 2; c++) tick(1);
      m_ready = 1'b0;
      for (int i = 0; i < 2; i++) fq.push_back(WIDTH'($urandom));
      tick(8);
      n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered: got valid %b want 1", m_valid); end
      for (int i = 0; i < 3; i++) begin
         w[i] = WIDTH'($urandom);
         fq.push_back(w[i]);
      end
      rst = 1'b1;
      #1;
      n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", m_valid); end
      n_chk++; if (rd_count !== '0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", rd_count); end
      n_chk++; if (m_data !== '0) begin n_fail++; $display("FAIL mid_data: got %h want 0", m_data); end
      n_chk++; if (fifo_ren_ !== 1'b1) begin n_fail++; $display("FAIL mid_ren: got %b want 1", fifo_ren_); end
      n_chk++; if (fifo_oe_ !== 1'b1) begin n_fail++; $display("FAIL mid_oe: got %b want 1", fifo_oe_); end
      tick(2);
      got.delete();
      got_cyc.delete();
      rst = 1'b0;
      m_ready = 1'b1;
      for (int c = 0; c < 30 && got.size() < 3; c++) tick(1);
      n_chk++; if (got.size() != 3) begin n_fail++; $display("FAIL mid_words: got %0d want 3", got.size()); end
      for (int i = 0; i < got.size() && i < 3; i++) begin
         n_chk++; if (got[i] !== w[i]) begin n_fail++; $display("FAIL mid_data[%0d]: got %h want %h", i, got[i], w[i]); end
      end
      tick(2);
      n_chk++; if (rd_count !== CW'(3)) begin n_fail++; $display("FAIL mid_count3: got %0d want 3", rd_count); end
   endtask

   task automatic test_random_stream;
      logic [WIDTH-1:0] exp[$];
      logic [WIDTH-1:0] w;
      int sent = 0;
      m_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 600 && got.size() < 40; c++) begin
         if (sent < 40 && $urandom_range(1, 0) == 1) begin
            w = WIDTH'($urandom);
            fq.push_back(w);
            exp.push_back(w);
            sent++;
         end
         m_ready = $urandom_range(1, 0) == 1;
         tick(1);
      end
      n_chk++; if (got.size() != 40) begin n_fail++; $display("FAIL rnd_words: got %0d want 40", got.size()); end
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         n_chk++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, got[i], exp[i]); end
      end
      m_ready = 1'b1;
      tick(4);
      n_chk++; if (rd_count !== CW'(40)) begin n_fail++; $display("FAIL rnd_count: got %0d want 40", rd_count); end
   endtask

`ifdef FIFO_RD_OFFSET_READBACK_EN
   task automatic test_readback;
      logic [WIDTH-1:0] w[8];
      int p0, dones = 0;
      pae_off = 5;
      paf_off = 7;
      m_ready = 1'b1;
      do_reset();
      p0 = pops;
      for (int i = 0; i < 8; i++) begin
         w[i] = WIDTH'($urandom);
         fq.push_back(w[i]);
      end
      tick(5);
      cfg_req = 1'b1;
      tick(1);
      cfg_req = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick(1);
         if (cfg_done) begin
            dones++;
            n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL cfg_drained: got valid %b want 0", m_valid); end
            n_chk++; if (got.size() != pops - p0) begin n_fail++; $display("FAIL cfg_delivered: got %0d want %0d", got.size(), pops - p0); end
         end
      end
      n_chk++; if (dones != 1) begin n_fail++; $display("FAIL cfg_pulses: got %0d want 1", dones); end
      n_chk++; if (cfg_pae_off !== 11'd5) begin n_fail++; $display("FAIL cfg_pae: got %0d want 5", cfg_pae_off); end
      n_chk++; if (cfg_paf_off !== 11'd7) begin n_fail++; $display("FAIL cfg_paf: got %0d want 7", cfg_paf_off); end
      for (int c = 0; c < 40 && got.size() < 8; c++) tick(1);
      n_chk++; if (got.size() != 8) begin n_fail++; $display("FAIL cfg_words: got %0d want 8", got.size()); end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         n_chk++; if (got[i] !== w[i]) begin n_fail++; $display("FAIL cfg_data[%0d]: got %h want %h", i, got[i], w[i]); end
      end
      tick(2);
      n_chk++; if (rd_count !== CW'(8)) begin n_fail++; $display("FAIL cfg_count: got %0d want 8", rd_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_empty();
      test_backpressure();
      test_reset_mid();
      test_random_stream();
`ifdef FIFO_RD_OFFSET_READBACK_EN
      test_readback();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
